// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and a
// constant-foldable ceiling-log2 used to size counters and domain indices.
package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        StHold,
        StWait,
        StRun,
        StSwHold,
        StFault
    } state_e;

    // Smallest r with 2**r >= value; evaluated at elaboration time only.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/reset_sequencer_sync2.sv
// Two-flop synchronizer for a bundle of independent asynchronous level
// signals. Bits are synchronized individually; no cross-bit coherence.
module reset_sequencer_sync2
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned Width = 1
) (
    input  logic             clock,
    input  logic             areset,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    // Metastability-settling flop followed by the stable output flop.
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Sequenced reset release across N_DOMAINS downstream domains. Waits for a
// stable PLL lock, then releases domains one at a time in index order, each
// only after the previous one acknowledges. Supports software re-reset of a
// domain suffix and latches a fault when a domain never acknowledges.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned N_DOMAINS      = 4,
    parameter int unsigned HOLD_CYCLES    = 256,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                                clock,
    input  logic                                areset,
    input  logic                                lock_i,
    input  logic [N_DOMAINS-1:0]                dom_ack_i,
    input  logic [N_DOMAINS-1:0]                sw_req_i,
    output logic [N_DOMAINS-1:0]                dom_reset_o,
    output logic                                done_o,
    output logic                                busy_o,
    output logic                                error_o,
    output logic [clog2(N_DOMAINS)-1:0]         err_domain_o
);

    localparam int unsigned IdxW   = clog2(N_DOMAINS);
    localparam int unsigned CntMax = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES
                                                                    : TIMEOUT_CYCLES;
    localparam int unsigned CntW   = clog2(CntMax);

    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] ToLast   = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(N_DOMAINS - 1);

    // Synchronized copies of the asynchronous inputs.
    logic                 lock_s;
    logic [N_DOMAINS-1:0] ack_s;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [IdxW-1:0]      idx_inc;
    logic [CntW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [CntW-1:0]      to_cnt_q, to_cnt_d;
    logic [N_DOMAINS-1:0] dom_reset_q, dom_reset_d;
    logic [IdxW-1:0]      err_domain_q, err_domain_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 error_q, error_d;

    // Software request decode: lowest requested domain and the suffix mask.
    logic [IdxW-1:0]      sw_idx;
    logic [N_DOMAINS-1:0] sw_mask;
    logic                 sw_seen;

    reset_sequencer_sync2 #(
        .Width (1)
    ) u_lock_sync (
        .clock  (clock),
        .areset (areset),
        .d_i    (lock_i),
        .q_o    (lock_s)
    );

    reset_sequencer_sync2 #(
        .Width (N_DOMAINS)
    ) u_ack_sync (
        .clock  (clock),
        .areset (areset),
        .d_i    (dom_ack_i),
        .q_o    (ack_s)
    );

    assign idx_inc = idx_q + IdxW'(1);

    // Lowest-set-bit priority encoder plus "this bit and everything above" mask.
    always_comb begin
        sw_idx  = '0;
        sw_mask = '0;
        sw_seen = 1'b0;
        for (int i = int'(N_DOMAINS) - 1; i >= 0; i--) begin
            if (sw_req_i[i]) begin
                sw_idx = IdxW'(i);
            end
        end
        for (int i = 0; i < int'(N_DOMAINS); i++) begin
            sw_seen    = sw_seen | sw_req_i[i];
            sw_mask[i] = sw_seen;
        end
    end

    // Next-state logic: a lost lock overrides everything except a latched fault.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        hold_cnt_d   = hold_cnt_q;
        to_cnt_d     = to_cnt_q;
        dom_reset_d  = dom_reset_q;
        err_domain_d = err_domain_q;

        if (state_q != StFault && !lock_s) begin
            state_d     = StHold;
            idx_d       = '0;
            hold_cnt_d  = '0;
            to_cnt_d    = '0;
            dom_reset_d = '1;
        end else begin
            unique case (state_q)
                StHold: begin
                    if (hold_cnt_q == HoldLast) begin
                        state_d        = StWait;
                        idx_d          = '0;
                        hold_cnt_d     = '0;
                        to_cnt_d       = '0;
                        dom_reset_d[0] = 1'b0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CntW'(1);
                    end
                end
                StWait: begin
                    // A stale high ack is accepted; ack wins over a same-cycle timeout.
                    if (ack_s[idx_q]) begin
                        to_cnt_d = '0;
                        if (idx_q == IdxLast) begin
                            state_d = StRun;
                        end else begin
                            idx_d                = idx_inc;
                            dom_reset_d[idx_inc] = 1'b0;
                        end
                    end else if (to_cnt_q == ToLast) begin
                        state_d      = StFault;
                        err_domain_d = idx_q;
                        to_cnt_d     = '0;
                        dom_reset_d  = '1;
                    end else begin
                        to_cnt_d = to_cnt_q + CntW'(1);
                    end
                end
                StRun: begin
                    if (|sw_req_i) begin
                        state_d     = StSwHold;
                        idx_d       = sw_idx;
                        hold_cnt_d  = '0;
                        to_cnt_d    = '0;
                        dom_reset_d = dom_reset_q | sw_mask;
                    end
                end
                StSwHold: begin
                    if (hold_cnt_q == HoldLast) begin
                        state_d            = StWait;
                        hold_cnt_d         = '0;
                        to_cnt_d           = '0;
                        dom_reset_d[idx_q] = 1'b0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CntW'(1);
                    end
                end
                StFault: begin
                    dom_reset_d = '1;
                end
                default: begin
                    state_d     = StHold;
                    idx_d       = '0;
                    hold_cnt_d  = '0;
                    to_cnt_d    = '0;
                    dom_reset_d = '1;
                end
            endcase
        end

        // Status flags are decoded from the next state so they register with it.
        done_d  = (state_d == StRun);
        error_d = (state_d == StFault);
        busy_d  = !done_d && !error_d;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            state_q      <= StHold;
            idx_q        <= '0;
            hold_cnt_q   <= '0;
            to_cnt_q     <= '0;
            dom_reset_q  <= '1;
            err_domain_q <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b1;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            hold_cnt_q   <= hold_cnt_d;
            to_cnt_q     <= to_cnt_d;
            dom_reset_q  <= dom_reset_d;
            err_domain_q <= err_domain_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
        end
    end

    assign dom_reset_o  = dom_reset_q;
    assign done_o       = done_q;
    assign busy_o       = busy_q;
    assign error_o      = error_q;
    assign err_domain_o = err_domain_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer (N=4, HOLD=16, TIMEOUT=64). A behavioural model
// tracks how many domains are released and countdown timers, and every cycle
// the DUT outputs are compared against it, plus directed edge-timing checks.
module tb_reset_sequencer;

    localparam int N = 4;
    localparam int H = 16;
    localparam int T = 64;

    localparam int PH_HOLD  = 0;
    localparam int PH_SEQ   = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_SWH   = 3;
    localparam int PH_FAULT = 4;

    logic       clock = 1'b0;
    logic       areset;
    logic       lock;
    logic [3:0] dom_ack;
    logic [3:0] sw_req;
    logic [3:0] dom_reset;
    logic       done;
    logic       busy;
    logic       error;
    logic [1:0] err_domain;

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_no;

    // Model state: phase, number of released domains, cycles left on the timer.
    int         m_phase, m_rel, m_left, m_err;
    bit         m_lk1, m_lk2;
    logic [3:0] m_ak1, m_ak2;

    // Acknowledge generator and timing trackers.
    int age[4];
    int dly[4];
    bit ack_en[4];
    int fall_edge[4];
    int err_edge;

    reset_sequencer #(
        .N_DOMAINS      (N),
        .HOLD_CYCLES    (H),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock        (clock),
        .areset       (areset),
        .lock_i       (lock),
        .dom_ack_i    (dom_ack),
        .sw_req_i     (sw_req),
        .dom_reset_o  (dom_reset),
        .done_o       (done),
        .busy_o       (busy),
        .error_o      (error),
        .err_domain_o (err_domain)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_HOLD;
        m_rel   = 0;
        m_left  = H;
        m_err   = 0;
        m_lk1   = 1'b0;
        m_lk2   = 1'b0;
        m_ak1   = '0;
        m_ak2   = '0;
    endtask

    // One clock edge of the model; inputs are what the DUT sampled at that edge.
    task automatic model_edge(input bit lk, input logic [3:0] ak, input logic [3:0] sw);
        bit         ls;
        logic [3:0] as_v;
        int         low;
        ls    = m_lk2;
        as_v  = m_ak2;
        m_lk2 = m_lk1;
        m_lk1 = lk;
        m_ak2 = m_ak1;
        m_ak1 = ak;
        if (m_phase != PH_FAULT && !ls) begin
            m_phase = PH_HOLD;
            m_rel   = 0;
            m_left  = H;
        end else begin
            case (m_phase)
                PH_HOLD: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = PH_SEQ;
                        m_rel   = 1;
                        m_left  = T;
                    end
                end
                PH_SEQ: begin
                    if (as_v[m_rel-1]) begin
                        if (m_rel == N) m_phase = PH_RUN;
                        else begin
                            m_rel++;
                            m_left = T;
                        end
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = PH_FAULT;
                            m_err   = m_rel - 1;
                            m_rel   = 0;
                        end
                    end
                end
                PH_RUN: begin
                    if (sw != 4'b0) begin
                        low     = int'(sw) & -int'(sw);
                        m_phase = PH_SWH;
                        m_rel   = $clog2(low);
                        m_left  = H;
                    end
                end
                PH_SWH: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = PH_SEQ;
                        m_rel++;
                        m_left = T;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_model();
        int exp_rst;
        exp_rst = (15 << m_rel) & 15;
        check("dom_reset", dom_reset, exp_rst);
        check("done", done, m_phase == PH_RUN);
        check("busy", busy, m_phase == PH_HOLD || m_phase == PH_SEQ || m_phase == PH_SWH);
        check("error", error, m_phase == PH_FAULT);
        check("err_domain", err_domain, m_err);
    endtask

    // Downstream domains acknowledge dly[i] cycles after their reset drops.
    task automatic drive_acks();
        for (int i = 0; i < N; i++) begin
            if (dom_reset[i] !== 1'b0) begin
                age[i]     = 0;
                dom_ack[i] = 1'b0;
            end else begin
                if (age[i] < 1000) age[i]++;
                dom_ack[i] = ack_en[i] && (age[i] > dly[i]);
            end
        end
    endtask

    task automatic step();
        bit         lk;
        logic [3:0] ak;
        logic [3:0] sw;
        lk = lock;
        ak = dom_ack;
        sw = sw_req;
        @(posedge clock);
        edge_no++;
        model_edge(lk, ak, sw);
        #1;
        check_model();
        for (int i = 0; i < N; i++) begin
            if (fall_edge[i] < 0 && dom_reset[i] === 1'b0) fall_edge[i] = edge_no;
        end
        if (err_edge < 0 && error === 1'b1) err_edge = edge_no;
        sw_req = '0;
        drive_acks();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset applied mid-cycle; outputs must change without an edge.
    task automatic do_reset(input string tag);
        areset  = 1'b1;
        lock    = 1'b0;
        sw_req  = '0;
        #1;
        check({tag, "_rst_dom_reset"}, dom_reset, 4'hF);
        check({tag, "_rst_done"}, done, 1'b0);
        check({tag, "_rst_busy"}, busy, 1'b1);
        check({tag, "_rst_error"}, error, 1'b0);
        check({tag, "_rst_err_domain"}, err_domain, 2'd0);
        dom_ack = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        areset  = 1'b0;
        edge_no = 0;
        err_edge = -1;
        for (int i = 0; i < N; i++) begin
            fall_edge[i] = -1;
            age[i]       = 0;
        end
    endtask

    task automatic wait_for(input int rel);
        for (int i = 0; i < 300; i++) begin
            if (m_phase == PH_SEQ && m_rel == rel) break;
            step();
        end
    endtask

    initial begin
        int e;
        int s;
        int lock_low;

        areset  = 1'b0;
        lock    = 1'b0;
        dom_ack = '0;
        sw_req  = '0;
        for (int i = 0; i < N; i++) begin
            dly[i]    = 0;
            ack_en[i] = 1'b1;
        end
        #3;

        // Power-up with immediate acks: releases at edges 18, 21, 24, 27.
        do_reset("pu");
        lock = 1'b1;
        run(40);
        check("pu_fall0", fall_edge[0], 18);
        check("pu_fall1", fall_edge[1], 21);
        check("pu_fall2", fall_edge[2], 24);
        check("pu_fall3", fall_edge[3], 27);
        check("pu_done", done, 1'b1);

        // Software re-reset of domains 1..3.
        sw_req = 4'b0110;
        step();
        s = edge_no;
        check("sw_mask", dom_reset, 4'b1110);
        fall_edge[1] = -1;
        run(40);
        check("sw_fall1", fall_edge[1], s + 16);
        check("sw_done", done, 1'b1);

        // Lock glitch while waiting on domain 2, random ack latencies.
        do_reset("gl");
        for (int i = 0; i < N; i++) dly[i] = $urandom_range(0, 4);
        lock = 1'b1;
        wait_for(3);
        check("gl_wait2", dom_reset, 4'b1000);
        lock = 1'b0;
        step();
        e = edge_no;
        lock = 1'b1;
        step();
        step();
        check("gl_all_reset", dom_reset, 4'hF);
        check("gl_done", done, 1'b0);
        fall_edge[0] = -1;
        run(30);
        check("gl_refall0", fall_edge[0], e + 18);
        run(60);

        // Request outside RUN is ignored.
        sw_req = 4'b0001;
        step();
        wait_for(2);
        check("ign_wait1", dom_reset, 4'b1100);
        sw_req = 4'b0001;
        step();
        run(60);
        check("ign_done", done, 1'b1);
        check("ign_released", dom_reset, 4'b0000);

        // Random soak: lock dropouts, requests and changing ack latencies.
        lock_low = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 59) == 0) lock_low = $urandom_range(1, 3);
            lock = (lock_low == 0);
            if (lock_low > 0) lock_low--;
            if ($urandom_range(0, 14) == 0) sw_req = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 29) == 0) dly[$urandom_range(0, 3)] = $urandom_range(0, 6);
            step();
        end
        lock = 1'b1;
        run(80);
        check("soak_done", done, 1'b1);

        // Timeout on domain 2, then the fault must survive lock loss and requests.
        do_reset("to");
        for (int i = 0; i < N; i++) dly[i] = 0;
        ack_en[2] = 1'b0;
        lock = 1'b1;
        run(100);
        check("to_error", error, 1'b1);
        check("to_err_domain", err_domain, 2'd2);
        check("to_latency", err_edge - fall_edge[2], T);
        check("to_all_reset", dom_reset, 4'hF);
        lock = 1'b0;
        run(3);
        lock = 1'b1;
        sw_req = 4'b0001;
        run(20);
        check("to_persist", error, 1'b1);
        ack_en[2] = 1'b1;

        // areset while in SW_HOLD, followed by a clean power-up.
        do_reset("sh");
        lock = 1'b1;
        run(40);
        sw_req = 4'($urandom_range(1, 15));
        step();
        run(5);
        check("sh_busy", busy, 1'b1);
        do_reset("sh2");
        lock = 1'b1;
        run(40);
        check("sh_fall0", fall_edge[0], 18);
        check("sh_fall3", fall_edge[3], 27);
        check("sh_done", done, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Single-clock controller that sequences reset release across `N_DOMAINS` downstream clock domains. It sits in the always-on clock domain, downstream of PLL lock, and drives per-domain reset requests into each domain's reset synchronizer. Domains are released strictly in index order; each must acknowledge before the next is released. Software can re-reset a domain suffix at runtime, and the block flags any domain that fails to acknowledge.

## Interface
- `N_DOMAINS`, 4: number of sequenced domains; 2..8.
- `HOLD_CYCLES`, 256: consecutive synchronized lock cycles required before domain 0 is released; also the software re-reset hold time. Must be ≥ 2.
- `TIMEOUT_CYCLES`, 4096: maximum wait for a domain acknowledge.
- `clock`  in  1  always-on sequencing clock.
- `areset`  in  1  asynchronous, active-high reset.
- `lock`  in  1  asynchronous; all PLLs locked.
- `dom_ack`  in  N_DOMAINS  asynchronous; bit i high once domain i is out of reset.
- `sw_req`  in  N_DOMAINS  synchronous single-cycle request to re-reset domain i and every higher domain.
- `dom_reset`  out  N_DOMAINS  per-domain reset request, active high.
- `done`  out  1  all domains released and acknowledged.
- `busy`  out  1  sequence in progress (HOLD, WAIT or SW_HOLD).
- `error`  out  1  timeout fault latched.
- `err_domain`  out  clog2(N_DOMAINS)  index of the timed-out domain.

## Operation
- `lock` and each `dom_ack` bit pass through 2-flop synchronizers to give `lock_s` and `ack_s`. All FSM decisions use only the synchronized values.
- States and behaviour:
  - HOLD: `hold_cnt` increments while `lock_s`=1 and clears to 0 when `lock_s`=0. On the edge where `lock_s`=1 and `hold_cnt`=HOLD_CYCLES-1, go to WAIT with idx=0 and clear `dom_reset[0]`.
  - WAIT(idx): `to_cnt` increments each cycle.
    - `ack_s[idx]`=1: clear `to_cnt`. If idx<N-1, set idx+1 and clear `dom_reset[idx+1]` on the same edge. If idx=N-1, go to RUN.
    - `to_cnt`=TIMEOUT_CYCLES-1 with no ack: go to FAULT and latch `err_domain`=idx.
  - RUN: `done`=1. If `sw_req`≠0, take k = lowest set bit, set `dom_reset[N-1:k]`, clear `hold_cnt`, and go to SW_HOLD with idx=k.
  - SW_HOLD: count HOLD_CYCLES cycles, then go to WAIT(idx), clearing `dom_reset[idx]`.
  - FAULT: all `dom_reset`=1, `error`=1. Only `areset` exits this state.
- A `lock_s` fall in any state other than FAULT sets all `dom_reset`, clears `done`, and goes to HOLD with `hold_cnt`=0. This takes priority over every other transition.
- `sw_req` is ignored outside RUN. In RUN, a `sw_req` arriving on the same edge as a `lock_s` fall is dropped.
- Before releasing domain i, the block does not check that `ack_s[i]` is low; a stale high ack is accepted immediately.
- `dom_reset` bits below the current idx stay at 0 during WAIT and SW_HOLD. Bits at or above idx stay at 1, except the bit for the current idx once it is released.

## Timing
- Values on `areset` (asynchronous): state=HOLD, `dom_reset`=all 1, `done`=0, `busy`=1, `error`=0, `err_domain`=0, all counters and synchronizers 0.
- `lock` to `lock_s` latency: 2 edges.
- Edge numbering for release of domain 0: edge 1 is the first edge at which `lock`=1.
  - `lock_s` is 1 at edge 3.
  - `dom_reset[0]` falls at edge 2+HOLD_CYCLES.
- Per-domain step: `dom_reset[i+1]` falls exactly 2 edges after the first edge that samples `dom_ack[i]`=1.
- `done` rises on the same edge as the transition to RUN. `busy` is the registered complement of `done` & !`error`.
- Counters are sized clog2(max(HOLD_CYCLES, TIMEOUT_CYCLES)) bits and never wrap: each is cleared on every state change.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `reset_sequencer_pkg` holds the state enum (HOLD, WAIT, RUN, SW_HOLD, FAULT) and a `clog2` function for the counter and index widths.
- One sub-module, `reset_sequencer_sync2`: a parameterized-width 2-flop synchronizer with asynchronous clear. It is instantiated once for `lock` and once for `dom_ack`.
- The FSM, counters and lowest-set-bit priority encoder live in the top level.

## Test plan
All scenarios use N_DOMAINS=4, HOLD_CYCLES=16, TIMEOUT_CYCLES=64.

- **Power-up:** `lock`=1 from edge 1, each ack echoes its `dom_reset` after 1 cycle → `dom_reset[0]` falls at edge 18; domains 1..3 follow in order, 3 edges apart; `done`=1, `busy`=0.
- **Lock glitch:** `lock` drops for 1 cycle while in WAIT(2) → all `dom_reset`=1 two edges later, `done`=0; the full sequence restarts and `dom_reset[0]` falls 18 edges after `lock` returns.
- **Timeout:** `dom_ack[2]` held at 0 → FAULT 64 edges after `dom_reset[2]` falls; `error`=1, `err_domain`=2, all `dom_reset`=1; the state persists until `areset`.
- **Software re-reset:** in RUN, pulse `sw_req`=4'b0110 → `dom_reset`=4'b1110 next edge; 16 cycles later `dom_reset[1]` falls; domains 2 and 3 re-sequence; `dom_reset[0]` never rises.
- **Ignored request:** `sw_req`=4'b0001 pulsed in WAIT(1) → no effect; the sequence completes normally.
- **areset mid-sequence:** assert `areset` in SW_HOLD → same cycle: `dom_reset`=4'b1111, `done`=0, `error`=0; after release, a normal power-up sequence follows.
